// File: rtl/booth_div_seq.sv
// Sequential signed divider: restoring radix-2 iteration on operand magnitudes,
// one quotient bit per clock, then a sign-fix step that registers the results.
module booth_div_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH:0]   dsr_mag_q, dsr_mag_d;
  logic             q_neg_q, q_neg_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dsr_ext, dsr_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  // An unsigned WIDTH-bit magnitude holds 2^(WIDTH-1) exactly; the divisor keeps
  // WIDTH+1 bits so the trial subtraction stays signed without extension.
  assign dvd_mag = dividend_i[WIDTH-1] ? (~dividend_i + WIDTH'(1)) : dividend_i;
  assign dsr_ext = {divisor_i[WIDTH-1], divisor_i};
  assign dsr_mag = divisor_i[WIDTH-1] ? (~dsr_ext + (WIDTH+1)'(1)) : dsr_ext;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - dsr_mag_q;

  assign q_fix = q_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
  assign r_fix = dvd_q[WIDTH-1] ? (~rem_q + WIDTH'(1)) : rem_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvd_d         = dvd_q;
    dsr_mag_d     = dsr_mag_q;
    q_neg_d       = q_neg_q;
    dz_d          = dz_q;
    ovf_d         = ovf_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    done_d        = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          quo_d     = dvd_mag;
          rem_d     = '0;
          cnt_d     = '0;
          dvd_d     = dividend_i;
          dsr_mag_d = dsr_mag;
          q_neg_d   = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
          dz_d      = (divisor_i == '0);
          ovf_d     = (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_i == '1);
          state_d   = StCalc;
        end
      end
      StCalc: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // The overflow case wraps naturally to -2^(WIDTH-1) with remainder 0.
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else begin
          quotient_d  = q_fix;
          remainder_d = r_fix;
        end
        div_by_zero_d = dz_q;
        overflow_d    = ovf_q && !dz_q;
        done_d        = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvd_q         <= '0;
      dsr_mag_q     <= '0;
      q_neg_q       <= 1'b0;
      dz_q          <= 1'b0;
      ovf_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvd_q         <= dvd_d;
      dsr_mag_q     <= dsr_mag_d;
      q_neg_q       <= q_neg_d;
      dz_q          <= dz_d;
      ovf_q         <= ovf_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = div_by_zero_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_booth_div_seq.sv
// Scoreboard bench for booth_div_seq: directed vectors, ignored start, mid-op reset,
// then random signed pairs against a behavioural reference.
module tb_booth_div_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, dz, ovf;
  logic [7:0] quo, rem;

  booth_div_seq #(.WIDTH(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quo),
    .remainder_o  (rem),
    .div_by_zero_o(dz),
    .overflow_o   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic [7:0] last_q = '0, last_r = '0;
  logic       last_dz = 1'b0, last_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic signed [7:0] a, input logic signed [7:0] b);
    exp_t e;
    e.acc = 0;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    if (b == 0) begin
      e.q  = 8'hFF;
      e.r  = a;
      e.dz = 1'b1;
    end else if (a == -8'sd128 && b == -8'sd1) begin
      e.q  = 8'h80;
      e.r  = 8'h00;
      e.ov = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Monitor: pops on done, otherwise confirms outputs hold the last result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", quo, e.q);
          chk("remainder", rem, e.r);
          chk("div_by_zero", dz, e.dz);
          chk("overflow", ovf, e.ov);
          chk("latency", cyc - e.acc, 9);
          chk("busy_at_done", busy, 0);
          last_q  = e.q;
          last_r  = e.r;
          last_dz = e.dz;
          last_ov = e.ov;
        end
      end else begin
        chk("hold", {quo, rem, dz, ovf}, {last_q, last_r, last_dz, last_ov});
      end
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("busy_timeout", 1, 0);
    end else begin
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      e.acc    = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_q"}, quo, 0);
    chk({nm, "_r"}, rem, 0);
    chk({nm, "_dz"}, dz, 0);
    chk({nm, "_ov"}, ovf, 0);
  endtask

  // {dividend, divisor, q, r, dz, ov}, hand-computed
  logic [7:0] vec [9][6] = '{
    '{8'd100, 8'd7,   8'h0E, 8'h02, 8'd0, 8'd0},
    '{8'h9C,  8'd7,   8'hF2, 8'hFE, 8'd0, 8'd0},
    '{8'd100, 8'hF9,  8'hF2, 8'h02, 8'd0, 8'd0},
    '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 8'd0, 8'd0},
    '{8'h80,  8'hFF,  8'h80, 8'h00, 8'd0, 8'd1},
    '{8'h80,  8'h01,  8'h80, 8'h00, 8'd0, 8'd0},
    '{8'd3,   8'd5,   8'h00, 8'h03, 8'd0, 8'd0},
    '{8'd5,   8'd0,   8'hFF, 8'h05, 8'd1, 8'd0},
    '{8'd6,   8'd3,   8'h02, 8'h00, 8'd0, 8'd0}
  };

  initial begin
    exp_t e;
    int   n;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      e.q  = vec[i][2];
      e.r  = vec[i][3];
      e.dz = vec[i][4][0];
      e.ov = vec[i][5][0];
      do_op(vec[i][0], vec[i][1], e);
      if (i == 0) begin
        // A start while busy must not disturb the operation in flight.
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 8'h81;
        divisor  = 8'h03;
        @(negedge clk);
        start    = 1'b0;
      end
    end

    e.q  = 8'd16;
    e.r  = 8'd2;
    e.dz = 1'b0;
    e.ov = 1'b0;
    do_op(8'd50, 8'd3, e);
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;
    last_ov = 1'b0;
    sb.delete();
    #1 chk_zero("midop_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 2000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 15) == 0) b = 8'h00;
      if ($urandom_range(0, 31) == 0) begin
        a = 8'h80;
        b = 8'hFF;
      end
      do_op(a, b, model(a, b));
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
